// File: rtl/i2c_slave_regfile.sv
// I2C target with an NREGS x 8-bit register bank, filtered SCL/SDA inputs and open-drain SDA.
// First written byte after the address sets the pointer; later bytes write the bank and auto-increment.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0]  I2C_ADDR   = 7'h42,
    parameter int unsigned NREGS      = 8,
    parameter int unsigned FILTER_LEN = 3,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          reg_wr,
    output logic [AW-1:0] reg_wr_addr,
    output logic [7:0]    reg_wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    localparam int unsigned FW   = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {IDLE, ADDR, AACK, WR, WACK, RD, RACK, IGNORE} state_t;

    // index 1 = SCL, index 0 = SDA
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [FW-1:0] fcnt [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {scl_i, sda_i};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FMAX) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_rise = scl_f & ~filt_d[1];
    assign scl_fall = ~scl_f & filt_d[1];
    assign start    = scl_f & filt_d[1] & filt_d[0] & ~sda_f;
    assign stop     = scl_f & filt_d[1] & ~filt_d[0] & sda_f;

    state_t        state, state_n;
    logic [7:0]    shift, shift_n, in_byte, rd_byte;
    logic [3:0]    bcnt, bcnt_n;
    logic [AW-1:0] ptr, ptr_n, wr_addr_n;
    logic [7:0]    wr_data_n;
    logic          first, first_n, rw, rw_n, oe_n, busy_n, wr_n;
    logic [7:0]    bank [NREGS];

    assign rd_data = bank[rd_addr];

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bcnt_n    = bcnt;
        ptr_n     = ptr;
        first_n   = first;
        rw_n      = rw;
        oe_n      = sda_oe;
        busy_n    = busy;
        wr_n      = 1'b0;
        wr_addr_n = reg_wr_addr;
        wr_data_n = reg_wr_data;
        in_byte   = {shift[6:0], sda_f};
        rd_byte   = bank[ptr];
        if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            bcnt_n  = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n = in_byte;
                    bcnt_n  = bcnt + 4'd1;
                    if (bcnt == 4'd7) begin
                        if (in_byte[7:1] == I2C_ADDR) begin
                            state_n = AACK;
                            rw_n    = in_byte[0];
                            busy_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                // ACK slots: bcnt=8 means ACK not yet driven, bcnt=9 means the 9th SCL rise has passed
                AACK: if (scl_rise) begin
                    bcnt_n = 4'd9;
                end else if (scl_fall && bcnt == 4'd8) begin
                    oe_n = 1'b1;
                end else if (scl_fall && bcnt == 4'd9) begin
                    bcnt_n = '0;
                    if (rw) begin
                        state_n = RD;
                        oe_n    = ~rd_byte[7];
                        shift_n = {rd_byte[6:0], 1'b0};
                    end else begin
                        state_n = WR;
                        oe_n    = 1'b0;
                        first_n = 1'b1;
                    end
                end
                WR: if (scl_rise) begin
                    shift_n = in_byte;
                    bcnt_n  = bcnt + 4'd1;
                    if (bcnt == 4'd7) begin
                        state_n = WACK;
                        if (first) begin
                            ptr_n   = in_byte[AW-1:0];
                            first_n = 1'b0;
                        end else begin
                            wr_n      = 1'b1;
                            wr_addr_n = ptr;
                            wr_data_n = in_byte;
                            ptr_n     = ptr + AW'(1);
                        end
                    end
                end
                WACK: if (scl_rise) begin
                    bcnt_n = 4'd9;
                end else if (scl_fall && bcnt == 4'd8) begin
                    oe_n = 1'b1;
                end else if (scl_fall && bcnt == 4'd9) begin
                    oe_n    = 1'b0;
                    state_n = WR;
                    bcnt_n  = '0;
                end
                RD: if (scl_rise) begin
                    bcnt_n = bcnt + 4'd1;
                end else if (scl_fall) begin
                    if (bcnt == 4'd8) begin
                        oe_n    = 1'b0;
                        ptr_n   = ptr + AW'(1);
                        state_n = RACK;
                    end else begin
                        oe_n    = ~shift[7];
                        shift_n = {shift[6:0], 1'b0};
                    end
                end
                RACK: if (scl_rise) begin
                    if (sda_f) state_n = IGNORE;
                    else       bcnt_n  = 4'd9;
                end else if (scl_fall && bcnt == 4'd9) begin
                    state_n = RD;
                    bcnt_n  = '0;
                    oe_n    = ~rd_byte[7];
                    shift_n = {rd_byte[6:0], 1'b0};
                end
                IGNORE: begin
                    oe_n   = 1'b0;
                    busy_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shift       <= '0;
            bcnt        <= '0;
            ptr         <= '0;
            first       <= 1'b0;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            bcnt        <= bcnt_n;
            ptr         <= ptr_n;
            first       <= first_n;
            rw          <= rw_n;
            sda_oe      <= oe_n;
            busy        <= busy_n;
            reg_wr      <= wr_n;
            reg_wr_addr <= wr_addr_n;
            reg_wr_data <= wr_data_n;
        end
    end

    // Bank commits at the end of the reg_wr pulse, so local readback shows the old byte during it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) bank[i] <= '0;
        end else if (reg_wr) begin
            bank[reg_wr_addr] <= reg_wr_data;
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bus master tasks, a reg_wr scoreboard queue and a bank model.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int unsigned Q = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_i, sda_i, sda_oe, busy, reg_wr;
    logic [2:0] reg_wr_addr, rd_addr;
    logic [7:0] reg_wr_data, rd_data;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_regfile #(.I2C_ADDR(7'h42), .NREGS(8), .FILTER_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe), .busy(busy),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] a; logic [7:0] d; logic [7:0] old; } wr_t;
    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [7:0] model [8];
    int         errors = 0;
    int         checks = 0;
    int         wr_count = 0;
    int         wc0;
    logic       oe_seen, busy_seen, ack;
    logic [7:0] v, e8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(2 * Q);
    endtask

    // optional 2-clk glitches: on SCL while low, or on SDA while SCL high
    task automatic put_bit(input logic b, input logic g_scl, input logic g_sda);
        sda_m = b; wclk(Q);
        if (g_scl) begin
            scl_m = 1'b1; wclk(2);
            scl_m = 1'b0; wclk(Q);
        end
        scl_m = 1'b1; wclk(Q);
        if (g_sda) begin
            sda_m = ~b; wclk(2);
            sda_m = b;
        end
        wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        b = sda_i;    wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic a, input logic [7:0] gs, input logic [7:0] gd);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i], gs[i], gd[i]);
        get_bit(b);
        a = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack, 1'b0, 1'b0);
    endtask

    task automatic exp_wr(input logic [2:0] a, input logic [7:0] d);
        wq.push_back('{a: a, d: d, old: model[a]});
        model[a] = d;
    endtask

    task automatic check_bank(input string tag);
        for (int unsigned i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check(tag, rd_data, model[i]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (reg_wr) begin
                wr_t e;
                wr_count++;
                if (wq.size() == 0) begin
                    check("reg_wr_unexpected", reg_wr, 1'b0);
                end else begin
                    e = wq.pop_front();
                    check("reg_wr_addr", reg_wr_addr, e.a);
                    check("reg_wr_data", reg_wr_data, e.d);
                    if (rd_addr == e.a) check("rd_data_old_during_wr", rd_data, e.old);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        rd_addr = 3'd0;
        wclk(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_reg_wr", reg_wr, 1'b0);
        check_bank("rst_bank");
        rst = 1'b1;
        wclk(10);

        // test 1: pointer 2, write A5, 3C
        rd_addr = 3'd3;
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00); check("t1_addr_ack", ack, 1'b1);
        check("t1_busy", busy, 1'b1);
        put_byte(8'h02, ack, 8'h00, 8'h00); check("t1_ptr_ack", ack, 1'b1);
        exp_wr(3'd2, 8'hA5);
        put_byte(8'hA5, ack, 8'h00, 8'h00); check("t1_d0_ack", ack, 1'b1);
        exp_wr(3'd3, 8'h3C);
        put_byte(8'h3C, ack, 8'h00, 8'h00); check("t1_d1_ack", ack, 1'b1);
        i2c_stop;
        check("t1_busy_after_stop", busy, 1'b0);
        check("t1_wq_drained", 32'(wq.size()), 32'd0);
        rd_addr = 3'd3; #1;
        check("t1_rd3", rd_data, 8'h3C);

        // wrap-around write: 7, 0, 1
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00); check("wrap_addr_ack", ack, 1'b1);
        put_byte(8'h07, ack, 8'h00, 8'h00);
        exp_wr(3'd7, 8'h5A); put_byte(8'h5A, ack, 8'h00, 8'h00);
        exp_wr(3'd0, 8'hC3); put_byte(8'hC3, ack, 8'h00, 8'h00);
        exp_wr(3'd1, 8'h96); put_byte(8'h96, ack, 8'h00, 8'h00);
        i2c_stop;
        check("wrap_wq_drained", 32'(wq.size()), 32'd0);
        check_bank("wrap_bank");

        // test 2: pointer 7, repeated START, read two bytes
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00);
        put_byte(8'h07, ack, 8'h00, 8'h00);
        i2c_start;
        put_byte(8'h85, ack, 8'h00, 8'h00); check("t2_rd_addr_ack", ack, 1'b1);
        rq.push_back(model[7]);
        rq.push_back(model[0]);
        get_byte(v, 1'b0); e8 = rq.pop_front(); check("t2_rd_byte0", v, e8);
        get_byte(v, 1'b1); e8 = rq.pop_front(); check("t2_rd_byte1", v, e8);
        check("t2_busy_after_nack", busy, 1'b0);
        i2c_stop;
        // pointer should now be 1
        i2c_start;
        put_byte(8'h85, ack, 8'h00, 8'h00);
        rq.push_back(model[1]);
        get_byte(v, 1'b1); e8 = rq.pop_front(); check("t2_ptr_persist", v, e8);
        i2c_stop;

        // test 3: foreign address
        oe_seen = 1'b0; busy_seen = 1'b0; wc0 = wr_count;
        i2c_start;
        put_byte(8'h90, ack, 8'h00, 8'h00); check("t3_addr_nack", ack, 1'b0);
        put_byte(8'h11, ack, 8'h00, 8'h00); check("t3_data_nack", ack, 1'b0);
        i2c_stop;
        check("t3_oe_never", oe_seen, 1'b0);
        check("t3_busy_never", busy_seen, 1'b0);
        check("t3_no_wr", 32'(wr_count), 32'(wc0));

        // test 4: glitches on SCL and SDA inside a data byte
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00);
        put_byte(8'h05, ack, 8'h00, 8'h00);
        exp_wr(3'd5, 8'h77);
        put_byte(8'h77, ack, 8'b0000_1000, 8'b0100_0000); check("t4_glitch_ack", ack, 1'b1);
        exp_wr(3'd6, 8'hE1);
        put_byte(8'hE1, ack, 8'h00, 8'h00); check("t4_next_ack", ack, 1'b1);
        i2c_stop;
        check("t4_wq_drained", 32'(wq.size()), 32'd0);
        check_bank("t4_bank");

        // test 5: STOP after 4 data bits, then a normal write
        wc0 = wr_count;
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00);
        put_byte(8'h01, ack, 8'h00, 8'h00);
        put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b0, 1'b0, 1'b0);
        put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b0, 1'b0, 1'b0);
        i2c_stop;
        check("t5_no_wr", 32'(wr_count), 32'(wc0));
        check("t5_busy", busy, 1'b0);
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00); check("t5_addr_ack", ack, 1'b1);
        put_byte(8'h02, ack, 8'h00, 8'h00);
        exp_wr(3'd2, 8'h11); put_byte(8'h11, ack, 8'h00, 8'h00);
        exp_wr(3'd3, 8'h22); put_byte(8'h22, ack, 8'h00, 8'h00);
        i2c_stop;
        check("t5_wq_drained", 32'(wq.size()), 32'd0);
        check_bank("t5_bank");

        // test 6: reset while driving a 0 data bit of a read (bank[7]=5A, MSB 0)
        i2c_start;
        put_byte(8'h84, ack, 8'h00, 8'h00);
        put_byte(8'h07, ack, 8'h00, 8'h00);
        i2c_start;
        put_byte(8'h85, ack, 8'h00, 8'h00);
        check("t6_pre_oe", sda_oe, 1'b1);
        check("t6_pre_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_oe_async", sda_oe, 1'b0);
        check("t6_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        check_bank("t6_bank_zero");
        wclk(3);
        rst = 1'b1;
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(2 * Q);
        check("t6_idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
